// File: rtl/version_pkg.sv
// Build-identification constants and the frame layout shared by the version
// reporter and anything else that needs to decode its byte stream.
package version_pkg;

  localparam logic [7:0]  C_VER_MAJOR  = 8'd2;
  localparam logic [7:0]  C_VER_MINOR  = 8'd7;
  localparam logic [7:0]  C_VER_PATCH  = 8'd13;
  localparam logic [7:0]  C_VER_BUILD  = 8'd142;
  localparam logic [15:0] C_VER_YEAR   = 16'd2024;
  localparam logic [7:0]  C_VER_MONTH  = 8'd6;
  localparam logic [7:0]  C_VER_DAY    = 8'd19;
  localparam logic [7:0]  C_VER_HOUR   = 8'd14;
  localparam logic [7:0]  C_VER_MINUTE = 8'd37;
  localparam logic [7:0]  C_VER_SECOND = 8'd52;

  localparam int unsigned C_VREPORT_LEN = 13;
  localparam logic [7:0]  C_CMD_BYTE    = 8'h56;
  localparam logic [7:0]  C_SYNC_BYTE   = 8'hA5;
  localparam int unsigned C_GAP_CYCLES  = 4;

  typedef enum logic [1:0] {VR_IDLE, VR_SEND, VR_CSUM, VR_GAP} vreport_state_t;

  // Payload byte for frame positions 1..11; year goes out big-endian.
  function automatic logic [7:0] vreport_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd1:    b = C_VER_MAJOR;
      4'd2:    b = C_VER_MINOR;
      4'd3:    b = C_VER_PATCH;
      4'd4:    b = C_VER_BUILD;
      4'd5:    b = C_VER_YEAR[15:8];
      4'd6:    b = C_VER_YEAR[7:0];
      4'd7:    b = C_VER_MONTH;
      4'd8:    b = C_VER_DAY;
      4'd9:    b = C_VER_HOUR;
      4'd10:   b = C_VER_MINUTE;
      4'd11:   b = C_VER_SECOND;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/version_report_tx.sv
// Emits one SYNC/payload/XOR-checksum frame of build identification per
// request, arriving either as a start pulse or as a command byte from the host.
module version_report_tx
  import version_pkg::*;
#(
  parameter logic [7:0]  CMD_BYTE   = C_CMD_BYTE,
  parameter logic [7:0]  SYNC_BYTE  = C_SYNC_BYTE,
  parameter int unsigned GAP_CYCLES = C_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] C_GAP_LOAD = 8'(GAP_CYCLES);

  vreport_state_t r_state, w_stateNext;
  logic [3:0] r_index, w_indexNext;
  logic [7:0] r_gap, w_gapNext;
  logic [7:0] r_csum, w_csumNext;
  logic       r_pending, w_pendingNext;
  logic       r_frameDone, w_frameDoneNext;
  logic       w_trigger;
  logic       w_accept;

  assign w_trigger = start | (rx_valid && (rx_data == CMD_BYTE));

  // Outputs decode from registered state only, so tx_ready never reaches tx_valid.
  always_comb begin
    tx_valid   = (r_state == VR_SEND) || (r_state == VR_CSUM);
    busy       = (r_state != VR_IDLE);
    frame_done = r_frameDone;
    w_accept   = tx_valid && tx_ready;
    case (r_state)
      VR_SEND: tx_data = (r_index == 4'd0) ? SYNC_BYTE : vreport_byte(r_index);
      VR_CSUM: tx_data = r_csum;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    w_stateNext     = r_state;
    w_indexNext     = r_index;
    w_gapNext       = r_gap;
    w_csumNext      = r_csum;
    w_pendingNext   = r_pending | (w_trigger && (r_state != VR_IDLE));
    w_frameDoneNext = 1'b0;
    case (r_state)
      VR_IDLE: begin
        if (w_trigger || r_pending) begin
          w_stateNext   = VR_SEND;
          w_indexNext   = 4'd0;
          w_csumNext    = 8'h00;
          w_pendingNext = 1'b0;
        end
      end
      VR_SEND: begin
        if (w_accept) begin
          if (r_index != 4'd0) w_csumNext = r_csum ^ vreport_byte(r_index);
          if (r_index == 4'd11) w_stateNext = VR_CSUM;
          else                  w_indexNext = r_index + 4'd1;
        end
      end
      VR_CSUM: begin
        if (w_accept) begin
          w_frameDoneNext = 1'b1;
          if (GAP_CYCLES == 0) begin
            w_stateNext = VR_IDLE;
          end else begin
            w_stateNext = VR_GAP;
            w_gapNext   = C_GAP_LOAD;
          end
        end
      end
      VR_GAP: begin
        // A trigger landing on the last gap cycle stays pending and IDLE picks it up.
        if (r_gap <= 8'd1) begin
          w_gapNext = 8'd0;
          if (r_pending) begin
            w_stateNext   = VR_SEND;
            w_indexNext   = 4'd0;
            w_csumNext    = 8'h00;
            w_pendingNext = 1'b0;
          end else begin
            w_stateNext = VR_IDLE;
          end
        end else begin
          w_gapNext = r_gap - 8'd1;
        end
      end
      default: w_stateNext = VR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= VR_IDLE;
      r_index     <= 4'd0;
      r_gap       <= 8'd0;
      r_csum      <= 8'h00;
      r_pending   <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_index     <= w_indexNext;
      r_gap       <= w_gapNext;
      r_csum      <= w_csumNext;
      r_pending   <= w_pendingNext;
      r_frameDone <= w_frameDoneNext;
    end
  end

endmodule

// File: tb/tb_version_report_tx.sv
// Self-checking bench for version_report_tx: random ready/idle timing, expected
// frames built from the frame rules with plain arithmetic.
module tb_version_report_tx;
  import version_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] expFrame [C_VREPORT_LEN];
  logic [7:0] capQ [$];
  int accCyc [$];
  int riseCyc [$];
  int doneCyc [$];
  int doneCnt, validCycles, busyCycles, stallViol, cyc;
  logic prevValid, stallPend;
  logic [7:0] stallData;

  version_report_tx dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference frame: sync, eleven payload bytes, then XOR of the payload only.
  task automatic buildExpected();
    logic [7:0] x;
    x = 8'h00;
    expFrame[0] = 8'hA5;
    for (int i = 1; i <= 11; i++) begin
      expFrame[i] = vreport_byte(4'(i));
      x = x ^ expFrame[i];
    end
    expFrame[12] = x;
  endtask

  task automatic clearMon();
    capQ.delete(); accCyc.delete(); riseCyc.delete(); doneCyc.delete();
    doneCnt = 0; validCycles = 0; busyCycles = 0; stallViol = 0;
  endtask

  // Observe the current cycle at the falling edge, then advance one clock.
  task automatic tick();
    if (!rst) begin
      if (tx_valid && tx_ready) begin capQ.push_back(tx_data); accCyc.push_back(cyc); end
      if (tx_valid && !prevValid) riseCyc.push_back(cyc);
      if (tx_valid) validCycles++;
      if (busy) busyCycles++;
      if (frame_done) begin doneCnt++; doneCyc.push_back(cyc); end
    end
    prevValid = rst ? 1'b0 : tx_valid;
    stallPend = !rst && tx_valid && !tx_ready;
    stallData = tx_data;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    start    = 1'b0;
    rx_valid = 1'b0;
    if (stallPend && !rst && (tx_valid !== 1'b1 || tx_data !== stallData)) stallViol++;
  endtask

  task automatic runUntilDone(input int n, input int budget);
    for (int i = 0; i < budget && doneCnt < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start_frame();
    int idle;
    clearMon();
    tx_ready = 1'b1;
    idle = $urandom_range(0, 7);
    for (int i = 0; i < idle; i++) tick();
    start = 1'b1;
    tick();
    checks += 3;
    if (tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL start_latency_valid got %b want 1", tx_valid); end
    if (tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL start_latency_data got %h want a5", tx_data); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_latency_busy got %b want 1", busy); end
    runUntilDone(1, 100);
    for (int i = 0; i < 10; i++) tick();
    checks += 4;
    if (capQ.size() != 13) begin errors++; $display("[TB] FAIL start_byte_count got %0d want 13", capQ.size()); end
    for (int k = 0; k < capQ.size() && k < 13; k++) begin
      checks++;
      if (capQ[k] !== expFrame[k]) begin errors++; $display("[TB] FAIL start_byte%0d got %h want %h", k, capQ[k], expFrame[k]); end
    end
    if (validCycles != 13) begin errors++; $display("[TB] FAIL start_valid_cycles got %0d want 13", validCycles); end
    if (busyCycles != 17) begin errors++; $display("[TB] FAIL start_busy_cycles got %0d want 17", busyCycles); end
    if (doneCnt != 1 || accCyc.size() < 13 || doneCyc[0] != accCyc[12] + 1) begin
      errors++;
      $display("[TB] FAIL start_frame_done_timing got count %0d want 1 pulse one cycle after csum", doneCnt);
    end
  endtask

  task automatic test_rx_cmd();
    clearMon();
    tx_ready = 1'b1;
    rx_data = 8'h55; rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (validCycles != 0 || busyCycles != 0) begin
      errors++; $display("[TB] FAIL rx_wrong_cmd got %0d valid cycles want 0", validCycles);
    end
    clearMon();
    rx_data = 8'h56; rx_valid = 1'b1;
    tick();
    runUntilDone(1, 100);
    for (int i = 0; i < 10; i++) tick();
    checks += 2;
    if (capQ.size() != 13) begin errors++; $display("[TB] FAIL rx_byte_count got %0d want 13", capQ.size()); end
    if (doneCnt != 1) begin errors++; $display("[TB] FAIL rx_done_count got %0d want 1", doneCnt); end
    for (int k = 0; k < capQ.size() && k < 13; k++) begin
      checks++;
      if (capQ[k] !== expFrame[k]) begin errors++; $display("[TB] FAIL rx_byte%0d got %h want %h", k, capQ[k], expFrame[k]); end
    end
  endtask

  task automatic test_stall();
    clearMon();
    tx_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2000 && doneCnt < 1; i++) begin
      tick();
      tx_ready = ($urandom_range(0, 99) < 30);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks += 3;
    if (stallViol != 0) begin errors++; $display("[TB] FAIL stall_hold got %0d violations want 0", stallViol); end
    if (capQ.size() != 13) begin errors++; $display("[TB] FAIL stall_byte_count got %0d want 13", capQ.size()); end
    if (doneCnt != 1) begin errors++; $display("[TB] FAIL stall_done_count got %0d want 1", doneCnt); end
    for (int k = 0; k < capQ.size() && k < 13; k++) begin
      checks++;
      if (capQ[k] !== expFrame[k]) begin errors++; $display("[TB] FAIL stall_byte%0d got %h want %h", k, capQ[k], expFrame[k]); end
    end
  endtask

  task automatic test_pending(input bit gapStart);
    clearMon();
    tx_ready = 1'b1;
    start = 1'b1;
    tick();
    tick(); tick();
    start = 1'b1; tick();
    tick();
    start = 1'b1; tick();
    runUntilDone(1, 100);
    if (gapStart) start = 1'b1;
    runUntilDone(2, 200);
    for (int i = 0; i < 30; i++) tick();
    checks += 4;
    if (doneCnt != 2) begin errors++; $display("[TB] FAIL pending%0d_frames got %0d want 2", gapStart, doneCnt); end
    if (capQ.size() != 26) begin errors++; $display("[TB] FAIL pending%0d_bytes got %0d want 26", gapStart, capQ.size()); end
    if (validCycles != 26) begin errors++; $display("[TB] FAIL pending%0d_valid got %0d want 26", gapStart, validCycles); end
    if (riseCyc.size() != 2 || accCyc.size() < 13 || riseCyc[1] - accCyc[12] - 1 != 4) begin
      errors++;
      $display("[TB] FAIL pending%0d_gap got %0d frame starts want 2 with 4 idle cycles between", gapStart, riseCyc.size());
    end
    for (int k = 0; k < capQ.size() && k < 26; k++) begin
      checks++;
      if (capQ[k] !== expFrame[k % 13]) begin
        errors++; $display("[TB] FAIL pending%0d_byte%0d got %h want %h", gapStart, k, capQ[k], expFrame[k % 13]);
      end
    end
  endtask

  task automatic test_both_triggers();
    clearMon();
    tx_ready = 1'b1;
    start = 1'b1; rx_data = 8'h56; rx_valid = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    checks += 2;
    if (doneCnt != 1) begin errors++; $display("[TB] FAIL both_frames got %0d want 1", doneCnt); end
    if (capQ.size() != 13) begin errors++; $display("[TB] FAIL both_bytes got %0d want 13", capQ.size()); end
  endtask

  task automatic test_reset_mid();
    clearMon();
    tx_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 50 && capQ.size() < 6; i++) begin
      if (capQ.size() == 3) start = 1'b1;
      tick();
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== expFrame[6]) begin
      errors++; $display("[TB] FAIL rstmid_presented got %h want %h", tx_data, expFrame[6]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", tx_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done got %b want 0", frame_done); end
    clearMon();
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (doneCnt != 0 || validCycles != 0) begin
      errors++; $display("[TB] FAIL rstmid_quiet got %0d valid cycles want 0", validCycles);
    end
    start = 1'b1;
    runUntilDone(1, 100);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (capQ.size() != 13) begin errors++; $display("[TB] FAIL rstmid_refr_count got %0d want 13", capQ.size()); end
    for (int k = 0; k < capQ.size() && k < 13; k++) begin
      checks++;
      if (capQ[k] !== expFrame[k]) begin errors++; $display("[TB] FAIL rstmid_byte%0d got %h want %h", k, capQ[k], expFrame[k]); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    cyc = 0; prevValid = 1'b0; stallPend = 1'b0; stallData = 8'h00;
    buildExpected();
    clearMon();
    @(negedge clk);
    test_reset();
    test_start_frame();
    test_rx_cmd();
    test_stall();
    test_pending(1'b0);
    test_pending(1'b1);
    test_both_triggers();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
